// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor: opcodes, register codes,
// default widths, instruction length decode and fetch state encoding.
package proc_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // One-byte register-to-register opcodes
  localparam logic [3:0] iadd   = 4'h0;
  localparam logic [3:0] isub   = 4'h1;
  localparam logic [3:0] iand   = 4'h2;
  localparam logic [3:0] ior    = 4'h3;
  localparam logic [3:0] ixor   = 4'h4;
  localparam logic [3:0] inot   = 4'h5;
  localparam logic [3:0] ishl   = 4'h6;
  localparam logic [3:0] ishr   = 4'h7;
  localparam logic [3:0] imov   = 4'h8;
  // Two-byte opcodes carrying an address operand
  localparam logic [3:0] read   = 4'h9;
  localparam logic [3:0] readi  = 4'hA;
  localparam logic [3:0] write  = 4'hB;
  localparam logic [3:0] writei = 4'hC;
  localparam logic [3:0] buc    = 4'hD;
  localparam logic [3:0] biz    = 4'hE;
  localparam logic [3:0] bio    = 4'hF;

  typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2, R3 = 2'd3} reg_e;

  typedef enum logic [1:0] {F1 = 2'd0, D1 = 2'd1, D2 = 2'd2, OUT = 2'd3} fetch_state_e;

  function automatic logic is_two_byte(input logic [3:0] op);
    return op >= read;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: reads one or two bytes per instruction from memory and
// hands complete instructions to decode over a valid/ready handshake.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        instr_op,
  output logic [1:0]        instr_rd,
  output logic [1:0]        instr_rs,
  output logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [3:0]        rdata_op;

  assign pc_inc   = pc + ADDR_W'(1);
  assign rdata_op = mem_rdata[7:4];

  // The second-byte read is issued in the same cycle the opcode arrives,
  // so the length decode works directly on the returning memory data.
  assign mem_rd   = rst && ((state == F1) || (state == D1 && is_two_byte(rdata_op)));
  assign mem_addr = (state == D1) ? pc_inc : pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= F1;
      pc          <= '0;
      instr_valid <= 1'b0;
      instr_op    <= '0;
      instr_rd    <= '0;
      instr_rs    <= '0;
      instr_imm   <= '0;
      instr_pc    <= '0;
    end else if (redir_valid) begin
      // Any partial instruction or in-flight read data is simply abandoned.
      state       <= F1;
      pc          <= redir_pc;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        F1: state <= D1;
        D1: begin
          instr_op  <= rdata_op;
          instr_rd  <= mem_rdata[3:2];
          instr_rs  <= mem_rdata[1:0];
          instr_imm <= '0;
          instr_pc  <= pc;
          pc        <= pc_inc;
          if (is_two_byte(rdata_op)) begin
            state <= D2;
          end else begin
            state       <= OUT;
            instr_valid <= 1'b1;
          end
        end
        D2: begin
          instr_imm   <= mem_rdata;
          pc          <= pc_inc;
          state       <= OUT;
          instr_valid <= 1'b1;
        end
        OUT: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= F1;
          end
        end
        default: state <= F1;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vectors, corner sequences
// and a randomized run against a transaction-level reference model.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [3:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs;
  logic [7:0] instr_imm;
  logic [7:0] instr_pc;
  logic       redir_valid = 1'b0;
  logic [7:0] redir_pc = '0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm(instr_imm), .instr_pc(instr_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data appears exactly one cycle after the read strobe.
  logic [7:0] mem [256];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!instr_valid && n < lim) begin
      step();
      n++;
    end
  endtask

  function automatic logic [23:0] outs();
    return {instr_op, instr_rd, instr_rs, instr_imm, instr_pc};
  endfunction

  // Reference: the instruction that starts at address a, from the length rule.
  function automatic logic [23:0] ref_instr(input logic [7:0] a);
    logic [7:0] b, a1, imm;
    b   = mem[a];
    a1  = a + 8'd1;
    imm = (b[7:4] > 4'd8) ? mem[a1] : 8'd0;
    return {b, imm, a};
  endfunction

  function automatic logic [7:0] ref_len(input logic [7:0] a);
    logic [7:0] b;
    b = mem[a];
    return (b[7:4] > 4'd8) ? 8'd2 : 8'd1;
  endfunction

  typedef struct {
    logic [7:0] a, b0, b1;
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm;
    int         lat;
    logic [7:0] nxt;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n;
    logic [7:0] a1, mp;
    logic [23:0] held;
    logic hold, accepted;
    int naccept;

    tbl[0] = '{8'h06, 8'h01, 8'h55, 4'h0, 2'd0, 2'd1, 8'h00, 2, 8'h07};
    tbl[1] = '{8'h0A, 8'hA7, 8'h3C, 4'hA, 2'd1, 2'd3, 8'h3C, 3, 8'h0C};
    tbl[2] = '{8'h14, 8'h8E, 8'h99, 4'h8, 2'd3, 2'd2, 8'h00, 2, 8'h15};
    tbl[3] = '{8'h1E, 8'h9B, 8'hFF, 4'h9, 2'd2, 2'd3, 8'hFF, 3, 8'h20};
    tbl[4] = '{8'h28, 8'hF0, 8'h00, 4'hF, 2'd0, 2'd0, 8'h00, 3, 8'h2A};
    tbl[5] = '{8'hFE, 8'h5D, 8'h11, 4'h5, 2'd3, 2'd1, 8'h00, 2, 8'hFF};
    tbl[6] = '{8'hFF, 8'hD4, 8'h04, 4'hD, 2'd1, 2'd0, 8'h04, 3, 8'h01};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h90;
    mem[1] = 8'd30;

    // Reset state
    step(); step();
    chk("rst_valid", instr_valid, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_outs", outs(), 0);

    // Two-byte instruction straight out of reset
    instr_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("boot_rd0", {mem_rd, mem_addr}, {1'b1, 8'h00});
    step();
    chk("boot_rd1", {mem_rd, mem_addr}, {1'b1, 8'h01});
    step();
    chk("boot_d2", {instr_valid, mem_rd}, 0);
    step();
    chk("boot_valid", instr_valid, 1);
    chk("boot_outs", outs(), {4'h9, 2'd0, 2'd0, 8'd30, 8'h00});

    // Directed vectors, each entered through a redirect
    for (int i = 0; i < 7; i++) begin
      mem[tbl[i].a] = tbl[i].b0;
      a1 = tbl[i].a + 8'd1;
      mem[a1] = tbl[i].b1;
      redir_valid = 1'b1;
      redir_pc = tbl[i].a;
      step();
      redir_valid = 1'b0;
      chk($sformatf("v%0d_redir_rd", i), {mem_rd, mem_addr}, {1'b1, tbl[i].a});
      wait_valid(10, n);
      chk($sformatf("v%0d_lat", i), n, tbl[i].lat);
      chk($sformatf("v%0d_outs", i), outs(),
          {tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, tbl[i].a});
      step();
      chk($sformatf("v%0d_next", i), {instr_valid, mem_rd, mem_addr}, {2'b01, tbl[i].nxt});
    end

    // Back-pressure: outputs held, no reads while waiting
    mem[50] = 8'h26;
    mem[51] = 8'h77;
    instr_ready = 1'b0;
    redir_valid = 1'b1; redir_pc = 8'd50;
    step();
    redir_valid = 1'b0;
    wait_valid(10, n);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d", i), {instr_valid, mem_rd, outs()},
          {2'b10, 4'h2, 2'd1, 2'd2, 8'h00, 8'd50});
    end
    instr_ready = 1'b1;
    step();
    chk("stall_next", {instr_valid, mem_rd, mem_addr}, {2'b01, 8'd51});

    // Redirect landing in D2 drops the half-fetched instruction
    mem[60] = 8'hB1; mem[61] = 8'h11; mem[4] = 8'h12;
    redir_valid = 1'b1; redir_pc = 8'd60;
    step();
    redir_valid = 1'b0;
    step(); step();
    redir_valid = 1'b1; redir_pc = 8'd4;
    step();
    redir_valid = 1'b0;
    chk("d2redir_rd", {instr_valid, mem_rd, mem_addr}, {2'b01, 8'd4});
    wait_valid(10, n);
    chk("d2redir_outs", outs(), {4'h1, 2'd0, 2'd2, 8'h00, 8'd4});

    // Reset pulse during D1
    mem[70] = 8'hE2; mem[71] = 8'h09;
    redir_valid = 1'b1; redir_pc = 8'd70;
    step();
    redir_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("d1rst", {instr_valid, mem_rd, outs()}, 0);
    step();
    rst = 1'b1;
    #1;
    chk("d1rst_rd0", {mem_rd, mem_addr}, {1'b1, 8'h00});

    // Randomized run against the reference model
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mp = 8'($urandom);
    redir_valid = 1'b1; redir_pc = mp;
    step();
    hold = 1'b0; held = '0; naccept = 0;
    for (int c = 0; c < 4000; c++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      redir_valid = ($urandom_range(0, 39) == 0);
      redir_pc = 8'($urandom);
      if (hold) chk("rnd_hold", {instr_valid, outs()}, {1'b1, held});
      accepted = instr_valid && instr_ready;
      if (accepted) begin
        chk("rnd_instr", outs(), ref_instr(mp));
        mp = mp + ref_len(mp);
        naccept++;
      end
      if (redir_valid) mp = redir_pc;
      hold = instr_valid && !instr_ready && !redir_valid;
      held = outs();
      step();
    end
    redir_valid = 1'b0;
    chk("rnd_progress", (naccept > 300), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the 8-bit processor. Reads instruction bytes from the 256x8 program/data memory, assembles one-byte (register) and two-byte (memory/branch, address operand) instructions, and presents each complete instruction to decode/execute over a valid/ready handshake. It accepts PC redirects from execute on taken branches.

## Interface
- ADDR_W, 8, memory address and PC width; PC wraps modulo 2^ADDR_W.
- DATA_W, 8, memory byte width; instruction byte = {op[3:0], rd[1:0], rs[1:0]}.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- mem_rd  out  1  read strobe; one read per cycle max.
- mem_addr  out  ADDR_W  read address, valid when mem_rd=1.
- mem_rdata  in  DATA_W  read data; valid exactly one cycle after the mem_rd cycle.
- instr_valid  out  1  complete instruction held on instr_* outputs.
- instr_ready  in  1  consumer accepts when instr_valid & instr_ready.
- instr_op  out  4  opcode.
- instr_rd  out  2  first register field (bits 3:2).
- instr_rs  out  2  second register field (bits 1:0).
- instr_imm  out  DATA_W  second byte for two-byte opcodes; 0 for one-byte.
- instr_pc  out  ADDR_W  address of the instruction's first byte.
- redir_valid  in  1  taken branch; fetch restarts at redir_pc.
- redir_pc  in  ADDR_W  branch target.

## Operation
- Length rule: op 4'b1001..4'b1111 (read, read-indirect, write, write-indirect, buc, biz, bio) are two-byte; op 4'b0000..4'b1000 are one-byte.
- States: F1 (issue read of first byte at pc), D1 (capture first byte; pc<=pc+1; if two-byte, issue read at pc+1 in the same cycle and go D2, else OUT), D2 (capture imm; pc<=pc+1; go OUT), OUT (instr_valid=1; on instr_ready go F1).
- mem_rd=1 only in F1 and in D1 when the captured opcode is two-byte; 0 otherwise.
- instr_* outputs are registered and stable while instr_valid=1 and not accepted.
- PC increments wrap: 8'hFF+1 = 8'h00; a two-byte instruction at 8'hFF takes its imm from 8'h00.
- Redirect: redir_valid in any state sets pc<=redir_pc and state<=F1 next cycle; any partially fetched instruction and any in-flight mem_rdata are discarded; instr_valid drops next cycle.
- Redirect coincident with instr_valid & instr_ready in OUT: the transfer counts as accepted; fetch resumes at redir_pc.
- Redirect wins over all internal transitions in the same cycle.

## Timing
- Reset (rst=0): pc=0, state=F1, instr_valid=0, mem_rd=0 (combinational, forced while in reset), instr_op/rd/rs/imm/pc=0. First mem_rd=1 at address 0 in the first cycle after rst deasserts.
- One-byte instruction: F1 at cycle t, instr_valid=1 at cycle t+2. Two-byte: valid at t+3.
- Throughput with instr_ready held high: one-byte every 3 cycles, two-byte every 4 cycles (accept cycle in OUT, then F1).
- Redirect at cycle t: mem_rd=1 at redir_pc at t+1; earliest instr_valid at t+3.
- Reset asserted mid-fetch: immediate return to reset values; no partial instruction survives.

## Structure
- Shared package proc_pkg: opcode constants (iadd..bio), register codes R0..R3, ADDR_W/DATA_W defaults, function is_two_byte(op), fetch state encoding.
- No sub-module; length decode is the package function. Single always block for state/PC/output registers, combinational mem_rd/mem_addr.

## Test plan
- Reset release, mem[0]=8'h90, mem[1]=8'd30, instr_ready=1 -> mem_rd at 0 then 1; instr_valid at cycle 3: op=9, rd=0, rs=0, imm=30, pc=0.
- mem[6]={iadd,R0,R1}=8'h01 fetched at pc=6 -> valid 2 cycles after F1: op=0, rd=0, rs=1, imm=0, pc=6; next fetch at address 7.
- instr_ready=0 for 5 cycles with valid instruction -> instr_* stable, mem_rd=0, no PC advance; accept then proceeds to next address.
- redir_valid with redir_pc=4 during D2 of a two-byte fetch -> partial instruction dropped, mem_rd at address 4 next cycle, next instr_pc=4.
- Two-byte op (buc) at 8'hFF, mem[0]=8'd4 -> imm=4, instr_pc=8'hFF, following fetch at 8'h01.
- rst pulsed low during D1 -> instr_valid=0, pc=0 immediately; after release first read at address 0.
